nn_layer1_dense: RTL and testbench
==================================

Name: nn_layer1_dense

Overview:
Second fully-connected stage of the neural network pipeline. It sits directly downstream of layer0.
- Starts when layer0 completes: its `req` is driven from layer0's `ack__layer`.
- Captures layer0's two signed 8-bit activations.
- Computes N_OUT outputs with one multiplier, time-shared: each output is a Q4.4 weighted sum, plus bias, then ReLU with saturation.
- Presents the outputs with a four-phase req/done handshake.
- Weights and biases live in a small register file written through a configuration port.

Parameters:
N_IN, 2, number of input activations (matches layer0 output count)
N_OUT, 2, number of output neurons
DW, 8, data width; signed Q4.4 for activations, weights and biases
ACC_W, 16, signed accumulator width
ADDR_W, 4, configuration address width; must satisfy 2^ADDR_W >= N_IN*N_OUT+N_OUT

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  1  start request, level; driven by layer0 ack__layer
x_in  in  N_IN*DW  input activations; element i is x_in[i*DW +: DW]; sampled only at start
cfg_we  in  1  configuration write strobe
cfg_addr  in  ADDR_W  configuration address
cfg_data  in  DW  configuration data (signed)
busy  out  1  high from start until done falls
done  out  1  results valid; held until req low
y_out  out  N_OUT*DW  output activations; element j is y_out[j*DW +: DW]

Behaviour:
- Reset: state=IDLE, busy=0, done=0, y_out=0, counters=0, accumulator=0. The weight/bias register file is NOT cleared by rst (contents retained). Reset mid-operation aborts immediately to IDLE with all of the above values.
- Config map: address a < N_IN*N_OUT writes weight w[j][i], where a = j*N_IN+i. Address N_IN*N_OUT+j writes bias b[j]. Higher addresses are ignored.
- Config writes are accepted only when busy=0; writes while busy=1 are dropped. A write in the same cycle as start is accepted and is visible to the computation.
- FSM states IDLE, MAC, FIN, DONE.
- IDLE:
  - Start when req=1 and done=0: latch x_in into the x register, set j=0, i=0, acc=0, busy=1, and go to MAC.
- MAC: each cycle, acc += (sext(w[j][i]) * sext(x[i])) >>> 4.
  - The product is a full 2*DW signed product.
  - The shift is arithmetic (floor); it does not truncate toward zero.
  - The sum is taken at ACC_W and wraps at ACC_W.
  - i increments each cycle; after i = N_IN-1, go to FIN.
- FIN (one cycle):
  - s = acc + sext(b[j]).
  - y[j] = 0 if s < 0; 127 if s > 127; otherwise s[DW-1:0].
  - Clear acc, set i=0.
  - If j = N_OUT-1, go to DONE with done=1; else j++ and return to MAC.
- DONE: done=1, busy=1, y_out stable. When req=0, go to IDLE with done=0 and busy=0 in the next cycle. y_out keeps its last value until the next FIN overwrites it.
- Latency: done rises N_OUT*(N_IN+1)+1 cycles after the cycle req is sampled high in IDLE. With defaults this is 7.
- req held high after done falls does not retrigger; done is only cleared via req=0.
- req dropped during MAC/FIN is ignored; the computation completes and done asserts. done then falls one cycle later because req is already 0.
- y_out updates element-wise during the run. Consumers sample only on done=1.

Test Plan:
- Basic run: load w00=16, w01=32, w10=-16, w11=8, b0=16, b1=-8; x0=32, x1=16; pulse req high. Required: done rises exactly 7 cycles after the start cycle, with y0=80 and y1=0 (ReLU of -32), busy=1 throughout.
- Saturation: all weights 127, x0=x1=127, biases 0. Required: y0=y1=127; accumulator must not overflow at ACC_W=16 (sum 2016).
- Floor shift: w00=-1, w01=0, b0=16, x0=1, x1=0. Required: y0=15, not 16.
- Handshake: hold req high for 20 cycles after done. Required: done stays 1, with no second computation. Drop req: done falls next cycle. Raise req again: a new run with identical results.
- Config while busy: write b0=0 during MAC. Required: the write is ignored and the result uses the old b0; a write after done falls is applied on the next run.
- Reset mid-run: assert rst in the second MAC cycle. Required: next cycle state=IDLE, done=0, busy=0, y_out=0. The following run reproduces the basic-run values, with weights retained.

Source files
------------

// File: rtl/nn_layer1_dense.sv
// nn_layer1_dense: second fully-connected layer. One multiplier is shared
// across all N_OUT*N_IN products. Arithmetic is Q4.4: product >>> 4,
// accumulate, add bias, then ReLU with saturation to the positive DW range.
// Results are presented with a four-phase req/done handshake.
//
// state | meaning
// IDLE  | waiting for req; coefficient writes accepted
// MAC   | one w[j][i]*x[i] product accumulated per cycle
// FIN   | add bias b[j], ReLU/saturate, store y[j]
// DONE  | results valid; waiting for req to drop
module nn_layer1_dense #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int DW     = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [N_IN*DW-1:0]    x_in,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DW-1:0]         cfg_data,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*DW-1:0]   y_out
);
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DW - 1)) - 1);

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;
    state_t state, state_nxt;

    logic signed [DW-1:0]     w_mem [N_OUT][N_IN];
    logic signed [DW-1:0]     b_mem [N_OUT];
    logic signed [DW-1:0]     x_reg [N_IN];
    logic [DW-1:0]            y_reg [N_OUT];
    logic [IW-1:0]            i_cnt;
    logic [JW-1:0]            j_cnt;
    logic signed [ACC_W-1:0]  acc;

    logic                     start;
    logic signed [2*DW-1:0]   prod;
    logic signed [2*DW-1:0]   prod_sh;
    logic signed [ACC_W-1:0]  sum_b;
    logic [DW-1:0]            y_sat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; done is low in IDLE, so req alone starts a run
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    start     = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (i_cnt == I_LAST) state_nxt = FIN;
            end
            FIN: begin
                if (j_cnt == J_LAST) state_nxt = DONE;
                else                 state_nxt = MAC;
            end
            DONE: begin
                if (!req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Coefficient register file; intentionally not reset so weights survive rst.
    // Writes are only taken while idle, including the cycle a run starts.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (cfg_addr == ADDR_W'(j * N_IN + i)) w_mem[j][i] <= cfg_data;
                end
                if (cfg_addr == ADDR_W'(N_IN * N_OUT + j)) b_mem[j] <= cfg_data;
            end
        end
    end

    // Shared multiplier; >>> gives floor rounding on negative products
    assign prod    = (2*DW)'(w_mem[j_cnt][i_cnt]) * (2*DW)'(x_reg[i_cnt]);
    assign prod_sh = prod >>> 4;
    assign sum_b   = acc + ACC_W'(b_mem[j_cnt]);

    // ReLU with saturation to the largest positive DW value
    always_comb begin
        if (sum_b[ACC_W-1])    y_sat = '0;
        else if (sum_b > Y_MAX) y_sat = Y_MAX[DW-1:0];
        else                    y_sat = sum_b[DW-1:0];
    end

    // Datapath: input capture, MAC accumulation, per-neuron result store
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            for (int k = 0; k < N_IN; k++)  x_reg[k] <= '0;
            for (int k = 0; k < N_OUT; k++) y_reg[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_IN; k++) x_reg[k] <= x_in[k*DW +: DW];
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc + ACC_W'(prod_sh);
                    i_cnt <= i_cnt + IW'(1);
                end
                FIN: begin
                    y_reg[j_cnt] <= y_sat;
                    acc          <= '0;
                    i_cnt        <= '0;
                    if (j_cnt != J_LAST) j_cnt <= j_cnt + JW'(1);
                end
                default: ;
            endcase
        end
    end

    // Flatten result registers onto the output bus
    always_comb begin
        y_out = '0;
        for (int j = 0; j < N_OUT; j++) y_out[j*DW +: DW] = y_reg[j];
    end

endmodule

// File: tb/tb_nn_layer1_dense.sv
// Testbench for nn_layer1_dense: directed scenarios plus randomized runs,
// checked against a plain-arithmetic model of the layer.
module tb_nn_layer1_dense;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int DW     = 8;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                req;
    logic [N_IN*DW-1:0]  x_in;
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [DW-1:0]       cfg_data;
    logic                busy;
    logic                done;
    logic [N_OUT*DW-1:0] y_out;

    int n_checks = 0;
    int n_err    = 0;
    int sw [N_OUT][N_IN];
    int sb [N_OUT];
    int exp_y [N_OUT];
    bit m_busy = 1'b0;
    bit chk_en = 1'b0;

    nn_layer1_dense #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy), .done(done), .y_out(y_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int yel(input int j);
        return int'(y_out[j*DW +: DW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: floor(w*x/16) summed, wrapped to 16 bits, plus bias, clipped to [0,127]
    function automatic int model_y(input int j, input int x0, input int x1);
        int xs [N_IN];
        int a;
        int s;
        xs[0] = int'(byte'(x0));
        xs[1] = int'(byte'(x1));
        a = 0;
        for (int i = 0; i < N_IN; i++) begin
            a = a + ((sw[j][i] * xs[i]) >>> 4);
            a = int'(shortint'(a));
        end
        s = int'(shortint'(a + sb[j]));
        if (s < 0)   return 0;
        if (s > 127) return 127;
        return s;
    endfunction

    function automatic void shadow_wr(input int a, input int v);
        if (a < N_IN * N_OUT)              sw[a / N_IN][a % N_IN] = int'(byte'(v));
        else if (a < N_IN * N_OUT + N_OUT) sb[a - N_IN * N_OUT]   = int'(byte'(v));
    endfunction

    task automatic cfg_write(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(a);
        cfg_data = DW'(v);
        if (!m_busy) shadow_wr(a, v);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load_cfg(input int w00, input int w01, input int w10, input int w11,
                            input int b0, input int b1);
        cfg_write(0, w00); cfg_write(1, w01); cfg_write(2, w10);
        cfg_write(3, w11); cfg_write(4, b0);  cfg_write(5, b1);
    endtask

    // One full handshake. Optional write in the start cycle (accepted) and
    // one during MAC (must be dropped). x_in is scrambled after start.
    task automatic run(input int x0, input int x1, input int hold,
                       input bit pre_we, input int pre_a, input int pre_v,
                       input bit mid_we, input int mid_a, input int mid_v);
        int lat;
        lat  = -1;
        x_in = {DW'(x1), DW'(x0)};
        req  = 1'b1;
        if (pre_we) begin
            cfg_we   = 1'b1;
            cfg_addr = ADDR_W'(pre_a);
            cfg_data = DW'(pre_v);
            shadow_wr(pre_a, pre_v);
        end
        for (int j = 0; j < N_OUT; j++) exp_y[j] = model_y(j, x0, x1);
        m_busy = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            cfg_we = 1'b0;
            if (k == 1) x_in = N_IN*DW'($urandom);
            if (mid_we && k == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = ADDR_W'(mid_a);
                cfg_data = DW'(mid_v);
            end
            if (done) begin
                lat = k;
                break;
            end
            chk("run_busy", int'(busy), 1);
        end
        cfg_we = 1'b0;
        chk("latency", lat, 7);
        chk_en = 1'b1;
        repeat (hold) tick();
        chk_en = 1'b0;
        req = 1'b0;
        tick();
        chk("drop_done", int'(done), 0);
        chk("drop_busy", int'(busy), 0);
        m_busy = 1'b0;
    endtask

    // While results are presented: done, busy and y_out must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hold_done", int'(done), 1);
            chk("hold_busy", int'(busy), 1);
            for (int j = 0; j < N_OUT; j++) chk("hold_y", yel(j), exp_y[j]);
        end
    end

    initial begin
        int lat;
        rst = 1'b1; req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; x_in = '0;
        for (int j = 0; j < N_OUT; j++) begin
            sb[j] = 0;
            for (int i = 0; i < N_IN; i++) sw[j][i] = 0;
        end
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_y", int'(y_out), 0);
        rst = 1'b0;
        tick();

        // Basic run
        load_cfg(16, 32, -16, 8, 16, -8);
        run(32, 16, 3, 0, 0, 0, 0, 0, 0);
        chk("basic_y0", yel(0), 80);
        chk("basic_y1", yel(1), 0);

        // Long hold, then an identical rerun
        run(32, 16, 20, 0, 0, 0, 0, 0, 0);
        run(32, 16, 2, 0, 0, 0, 0, 0, 0);
        chk("rerun_y0", yel(0), 80);
        chk("rerun_y1", yel(1), 0);

        // Saturation
        load_cfg(127, 127, 127, 127, 0, 0);
        run(127, 127, 2, 0, 0, 0, 0, 0, 0);
        chk("sat_y0", yel(0), 127);
        chk("sat_y1", yel(1), 127);

        // Floor shift
        load_cfg(-1, 0, 0, 0, 16, 0);
        run(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("floor_y0", yel(0), 15);

        // Write during MAC is dropped; write after done falls applies next run
        load_cfg(16, 32, -16, 8, 16, -8);
        run(32, 16, 2, 0, 0, 0, 1, 4, 0);
        chk("busywr_y0", yel(0), 80);
        cfg_write(4, 0);
        run(32, 16, 2, 0, 0, 0, 0, 0, 0);
        chk("postwr_y0", yel(0), 64);

        // Write in the start cycle is visible to the run
        run(32, 16, 2, 1, 5, 100, 0, 0, 0);
        chk("startwr_y1", yel(1), 76);

        // req dropped mid-computation: run completes, done falls a cycle later
        load_cfg(16, 32, -16, 8, 16, -8);
        x_in = {DW'(16), DW'(32)};
        req  = 1'b1;
        m_busy = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2) req = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("early_latency", lat, 7);
        chk("early_y0", yel(0), 80);
        chk("early_y1", yel(1), 0);
        tick();
        chk("early_done_fall", int'(done), 0);
        m_busy = 1'b0;

        // Reset in the second MAC cycle
        load_cfg(16, 32, -16, 8, 16, 100);
        run(32, 16, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_y1", yel(1), 76);
        cfg_write(5, -8);
        x_in = {DW'(16), DW'(32)};
        req  = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        req = 1'b0;
        tick();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_y", int'(y_out), 0);
        rst = 1'b0;
        tick();
        run(32, 16, 2, 0, 0, 0, 0, 0, 0);
        chk("postrst_y0", yel(0), 80);
        chk("postrst_y1", yel(1), 0);

        // Randomized runs
        for (int n = 0; n < 25; n++) begin
            for (int a = 0; a < N_IN * N_OUT + N_OUT; a++)
                cfg_write(a, int'($urandom_range(0, 255)));
            cfg_write(int'($urandom_range(6, 15)), int'($urandom_range(0, 255)));
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 4)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
